reg_ctrl_sequencer: RTL and testbench
=====================================

// Module: reg_ctrl_sequencer
// PURPOSE
//  Upstream control stage for the 8-entry register file (r0-r6 GP, r7 = PC).
//  Multi-cycle fetch/decode/execute FSM. Holds the instruction register (IR).
//  Generates the file's active-low per-register output-enable/load strobes, pcInc and the PC reset.
//  Also sequences the memory handshake and the ALU/memory drivers on yBus.
// PARAMETERS
//  PC_IDX      7  register index that is the program counter
//  RESET_HOLD  2  cycles pcNotReset is held low after reset deasserts (>=1)
// PORTS
//  clock        in   1   single system clock, all state changes on posedge
//  reset        in   1   synchronous, active-high
//  instr        in   16  memory data word (instruction or immediate)
//  memAck       in   1   memory data valid this cycle
//  memReq       out  1   memory read request
//  addrNotLoad  out  1   active low: latch aBus into memory address register
//  memNotOE     out  1   active low: memory drives yBus
//  regNotOE     out  8   active low: register i drives aBus
//  regNotLoad   out  8   active low: register i loads yBus at next edge
//  pcNotReset   out  1   active low: synchronous PC clear
//  pcInc        out  1   PC increments at next edge
//  aluOp        out  4   ALU function (= IR[15:12])
//  aluANotLoad  out  1   active low: ALU operand-A latch loads aBus
//  aluNotOE     out  1   active low: ALU result drives yBus
//  halted       out  1   high in HALT state
//  illegal      out  1   sticky: halted on an undefined opcode
// BEHAVIOUR
//  - Outputs are a Moore decode of registered state+IR.
//  - Inactive levels: all NotX = 1; memReq, pcInc, halted = 0; aluOp = 0.
//  - Reset sampled high: next state RST, IR = 0, illegal = 0, hold counter = RESET_HOLD.
//  - IR format: op[15:12], rsvd[11:9] (ignored), dst[8:6], srcA[5:3], srcB[2:0].
//  - Ops: 0 NOP, 1 MOV dst<=srcA, 2 LDI dst<=next word, 3 NOT, 4 ADD, 5 SUB,
//    6 AND, 7 OR, 8 XOR, F HALT; 9-E illegal -> HALT with illegal = 1.
//  - States and actions:
//    RST: pcNotReset = 0 for RESET_HOLD cycles -> FETCH.
//    FETCH: regNotOE[PC_IDX] = 0, addrNotLoad = 0, memReq = 1 -> FWAIT.
//    FWAIT: memReq = 1; on memAck: IR <= instr, pcInc = 1 -> DECODE; else stay (no timeout).
//    DECODE: NOP -> FETCH; HALT/illegal -> HALT; LDI -> IADDR; op 4-8 -> OPA; MOV/NOT -> EXEC.
//    OPA: regNotOE[srcA] = 0, aluANotLoad = 0 -> EXEC.
//    EXEC: regNotOE[srcB] = 0 for op 4-8, [srcA] for MOV/NOT; aluNotOE = 0;
//      regNotLoad[dst] = 0 -> FETCH. Total ALU2 = 5 cycles (ex mem wait), MOV/NOT = 4.
//    IADDR: as FETCH -> IWAIT.
//    IWAIT: memReq = 1, memNotOE = 0; on memAck: regNotLoad[dst] = 0, pcInc = 1 -> FETCH.
//    HALT: halted = 1. Only reset exits.
//  - Invariants, every cycle:
//    at most one regNotOE bit low;
//    memNotOE and aluNotOE never both low;
//    at most one regNotLoad bit low.
//  - dst == PC_IDX (jump): pcInc is forced 0 in that cycle; load wins.
//  - srcA == srcB and dst == src are legal with no special casing.
//  - memAck outside FWAIT/IWAIT is ignored.
//  - Reset mid-operation, including mid-handshake: strobes take inactive levels from the next
//    cycle; memReq drops; no partial register load.
// STRUCTURE
//  - Shared header ctrl_defines.v (guarded `include):
//    opcode `defines OP_NOP..OP_HALT;
//    state encodings ST_RST..ST_HALT (4-bit);
//    IR field bit positions.
//  - Sub-module instr_decode: combinational IR -> {isAlu2, isUnary, isLdi, isHalt, isIllegal}.
//  - 3-bit index -> active-low one-hot helper lives in this module as a function.
// TESTING
//  1. reset high 1 cycle, then low:
//     pcNotReset low exactly 2 cycles; FETCH with regNotOE = 8'h7F, memReq = 1.
//  2. ADD r3,r1,r2 (16'h40CA), memAck after 3 wait cycles:
//     - pcInc 1 cycle;
//     - OPA regNotOE = 8'hFD, aluANotLoad = 0;
//     - EXEC regNotOE = 8'hFB, regNotLoad = 8'hF7, aluOp = 4.
//  3. LDI r7 (16'h21C0), immediate 16'h0100:
//     IWAIT regNotLoad = 8'h7F, memNotOE = 0, pcInc = 0; next state FETCH.
//  4. Opcode 16'hA000:
//     halted = 1, illegal = 1; stays halted over 20 cycles despite memAck toggling.
//  5. Reset asserted in FWAIT and in EXEC:
//     - next cycle all regNotOE/regNotLoad = 8'hFF, memReq = 0;
//     - no load strobe seen.
//  6. Random instruction stream, 2000 instrs, with an assertion monitor:
//     one-hot/yBus-single-driver invariants never violated.

Source files
------------

// File: rtl/reg_ctrl_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_ctrl_sequencer_pkg
// Purpose  : Shared types and constants for the register-file control
//            sequencer: FSM state encoding, opcodes, IR field helpers.
// Revision : 1.0  initial release
// ============================================================================
package reg_ctrl_sequencer_pkg;

  // Four-bit state encoding; any unlisted code falls back to RST.
  typedef enum logic [3:0] {
    ST_RST    = 4'd0,
    ST_FETCH  = 4'd1,
    ST_FWAIT  = 4'd2,
    ST_DECODE = 4'd3,
    ST_OPA    = 4'd4,
    ST_EXEC   = 4'd5,
    ST_IADDR  = 4'd6,
    ST_IWAIT  = 4'd7,
    ST_HALT   = 4'd8
  } state_t;

  // Opcodes carried in IR[15:12]; 9..E are undefined.
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_MOV  = 4'h1;
  localparam logic [3:0] OP_LDI  = 4'h2;
  localparam logic [3:0] OP_NOT  = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  // IR field positions: op[15:12], rsvd[11:9], dst[8:6], srcA[5:3], srcB[2:0].
  localparam int IR_OP_LSB   = 12;
  localparam int IR_DST_LSB  = 6;
  localparam int IR_SRCA_LSB = 3;
  localparam int IR_SRCB_LSB = 0;

  // Instruction class flags produced by the decoder.
  typedef struct packed {
    logic is_alu2;
    logic is_unary;
    logic is_ldi;
    logic is_halt;
    logic is_illegal;
  } dec_t;

  function automatic logic [3:0] ir_op(input logic [15:0] ir);
    return ir[IR_OP_LSB +: 4];
  endfunction

  function automatic logic [2:0] ir_dst(input logic [15:0] ir);
    return ir[IR_DST_LSB +: 3];
  endfunction

  function automatic logic [2:0] ir_srca(input logic [15:0] ir);
    return ir[IR_SRCA_LSB +: 3];
  endfunction

  function automatic logic [2:0] ir_srcb(input logic [15:0] ir);
    return ir[IR_SRCB_LSB +: 3];
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_ctrl_sequencer_instr_decode.sv
`default_nettype none
// ============================================================================
// Module   : reg_ctrl_sequencer_instr_decode
// Purpose  : Combinational opcode classifier: two-operand ALU, unary
//            (MOV/NOT), load-immediate, HALT and undefined opcodes.
// Revision : 1.0  initial release
// ============================================================================
module reg_ctrl_sequencer_instr_decode
  import reg_ctrl_sequencer_pkg::*;
(
  input  logic [3:0] i_op,
  output dec_t       o_dec
);

  // Classify the opcode; NOP leaves every flag clear.
  always_comb begin
    o_dec = '0;
    case (i_op)
      OP_NOP:                                o_dec = '0;
      OP_MOV, OP_NOT:                        o_dec.is_unary   = 1'b1;
      OP_LDI:                                o_dec.is_ldi     = 1'b1;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: o_dec.is_alu2    = 1'b1;
      OP_HALT:                               o_dec.is_halt    = 1'b1;
      default:                               o_dec.is_illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/reg_ctrl_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : reg_ctrl_sequencer
// Purpose  : Multi-cycle fetch/decode/execute controller for an 8-entry
//            register file (r7 = PC). Holds the IR and drives the file's
//            active-low strobes, the memory handshake and the ALU controls.
// Revision : 1.0  initial release
// ============================================================================
module reg_ctrl_sequencer
  import reg_ctrl_sequencer_pkg::*;
#(
  parameter int PC_IDX     = 7,
  parameter int RESET_HOLD = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic        memAck,
  output logic        memReq,
  output logic        addrNotLoad,
  output logic        memNotOE,
  output logic [7:0]  regNotOE,
  output logic [7:0]  regNotLoad,
  output logic        pcNotReset,
  output logic        pcInc,
  output logic [3:0]  aluOp,
  output logic        aluANotLoad,
  output logic        aluNotOE,
  output logic        halted,
  output logic        illegal
);

  localparam logic [2:0] c_PC_SEL    = 3'(PC_IDX);
  localparam logic [7:0] c_HOLD_INIT = 8'(RESET_HOLD);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_ir;
  logic        r_illegal;
  logic [7:0]  r_hold;
  dec_t        w_dec;
  logic [2:0]  w_dst;
  logic [2:0]  w_srca;
  logic [2:0]  w_srcb;
  logic [3:0]  w_op;

  // Index to active-low one-hot strobe vector.
  function automatic logic [7:0] sel_n(input logic [2:0] idx);
    return ~(8'b1 << idx);
  endfunction

  assign w_op   = ir_op(r_ir);
  assign w_dst  = ir_dst(r_ir);
  assign w_srca = ir_srca(r_ir);
  assign w_srcb = ir_srcb(r_ir);

  reg_ctrl_sequencer_instr_decode u_decode (
    .i_op  (w_op),
    .o_dec (w_dec)
  );

  // State register; reset always returns to RST.
  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_RST;
    else       r_state <= w_state_nxt;
  end

  // IR capture, sticky illegal flag and PC-reset hold counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ir      <= '0;
      r_illegal <= 1'b0;
      r_hold    <= c_HOLD_INIT;
    end else begin
      if (r_state == ST_FWAIT && memAck) r_ir <= instr;
      if (r_state == ST_DECODE && w_dec.is_illegal) r_illegal <= 1'b1;
      if (r_state == ST_RST && r_hold != 8'd0) r_hold <= r_hold - 8'd1;
    end
  end

  // Next-state and strobe decode; every output starts at its inactive level.
  always_comb begin
    w_state_nxt = r_state;
    memReq      = 1'b0;
    addrNotLoad = 1'b1;
    memNotOE    = 1'b1;
    regNotOE    = 8'hFF;
    regNotLoad  = 8'hFF;
    pcNotReset  = 1'b1;
    pcInc       = 1'b0;
    aluOp       = 4'h0;
    aluANotLoad = 1'b1;
    aluNotOE    = 1'b1;
    halted      = 1'b0;
    case (r_state)
      ST_RST: begin
        pcNotReset = 1'b0;
        if (r_hold <= 8'd1) w_state_nxt = ST_FETCH;
      end
      ST_FETCH, ST_IADDR: begin
        regNotOE    = sel_n(c_PC_SEL);
        addrNotLoad = 1'b0;
        memReq      = 1'b1;
        w_state_nxt = (r_state == ST_FETCH) ? ST_FWAIT : ST_IWAIT;
      end
      ST_FWAIT: begin
        memReq = 1'b1;
        if (memAck) begin
          pcInc       = 1'b1;
          w_state_nxt = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (w_dec.is_halt || w_dec.is_illegal) w_state_nxt = ST_HALT;
        else if (w_dec.is_ldi)                 w_state_nxt = ST_IADDR;
        else if (w_dec.is_alu2)                w_state_nxt = ST_OPA;
        else if (w_dec.is_unary)               w_state_nxt = ST_EXEC;
        else                                   w_state_nxt = ST_FETCH;
      end
      ST_OPA: begin
        regNotOE    = sel_n(w_srca);
        aluANotLoad = 1'b0;
        aluOp       = w_op;
        w_state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        // Two-operand ops present B here; A was latched in OPA.
        regNotOE    = w_dec.is_alu2 ? sel_n(w_srcb) : sel_n(w_srca);
        aluNotOE    = 1'b0;
        aluOp       = w_op;
        regNotLoad  = sel_n(w_dst);
        w_state_nxt = ST_FETCH;
      end
      ST_IWAIT: begin
        memReq   = 1'b1;
        memNotOE = 1'b0;
        if (memAck) begin
          regNotLoad  = sel_n(w_dst);
          // Loading the PC itself is a jump: the load must win over increment.
          pcInc       = (w_dst != c_PC_SEL);
          w_state_nxt = ST_FETCH;
        end
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: begin
        w_state_nxt = ST_RST;
      end
    endcase
  end

  assign illegal = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_reg_ctrl_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_ctrl_sequencer
// Purpose  : Self-checking bench: directed instruction table, halt/illegal,
//            reset-mid-operation sequences and a random stream with an
//            invariant monitor.
// Revision : 1.0  initial release
// ============================================================================
module tb_reg_ctrl_sequencer;

  localparam int K_NOP   = 0;
  localparam int K_UNARY = 1;
  localparam int K_ALU2  = 2;
  localparam int K_LDI   = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] instr = 16'h0;
  logic        memAck = 1'b0;
  logic        memReq, addrNotLoad, memNotOE, pcNotReset, pcInc;
  logic [7:0]  regNotOE, regNotLoad;
  logic [3:0]  aluOp;
  logic        aluANotLoad, aluNotOE, halted, illegal;

  int n_cmp  = 0;
  int n_fail = 0;
  logic mon_en = 1'b0;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] imm;
    int          kind;
    int          waits;
    logic [7:0]  oe_a;   // regNotOE in OPA
    logic [7:0]  oe_x;   // regNotOE in EXEC
    logic [7:0]  ld;     // regNotLoad in EXEC / IWAIT
    logic [3:0]  aop;
    logic        pinc;   // pcInc in IWAIT
  } vec_t;

  vec_t vecs[10];

  reg_ctrl_sequencer #(.PC_IDX(7), .RESET_HOLD(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .instr       (instr),
    .memAck      (memAck),
    .memReq      (memReq),
    .addrNotLoad (addrNotLoad),
    .memNotOE    (memNotOE),
    .regNotOE    (regNotOE),
    .regNotLoad  (regNotLoad),
    .pcNotReset  (pcNotReset),
    .pcInc       (pcInc),
    .aluOp       (aluOp),
    .aluANotLoad (aluANotLoad),
    .aluNotOE    (aluNotOE),
    .halted      (halted),
    .illegal     (illegal)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock, then apply this cycle's inputs; returns mid-cycle.
  task automatic cyc(input logic r, input logic a, input logic [15:0] d);
    @(posedge clock);
    #1;
    reset  = r;
    memAck = a;
    instr  = d;
    #3;
  endtask

  // Called while reset is asserted; releases it and checks RST then FETCH.
  task automatic reset_to_fetch();
    int lows;
    cyc(1'b0, 1'b0, 16'h0);
    chk("rst_regNotOE",   {8'h0, regNotOE},   16'hFF);
    chk("rst_regNotLoad", {8'h0, regNotLoad}, 16'hFF);
    chk("rst_memReq",     {15'h0, memReq},    16'h0);
    chk("rst_pcInc",      {15'h0, pcInc},     16'h0);
    chk("rst_halted",     {15'h0, halted},    16'h0);
    chk("rst_illegal",    {15'h0, illegal},   16'h0);
    chk("rst_yBus_drv",   {14'h0, memNotOE, aluNotOE}, 16'h3);
    lows = 0;
    for (int i = 0; i < 10; i++) begin
      if (pcNotReset !== 1'b0) break;
      lows++;
      cyc(1'b0, 1'b0, 16'h0);
    end
    chk("pcNotReset_low_cycles", 16'(lows), 16'd2);
    chk("fetch_regNotOE",    {8'h0, regNotOE},      16'h7F);
    chk("fetch_memReq",      {15'h0, memReq},       16'h1);
    chk("fetch_addrNotLoad", {15'h0, addrNotLoad},  16'h0);
  endtask

  // From a FETCH cycle: serve the instruction word after 'waits' idle cycles; ends in DECODE.
  task automatic fetch_word(input logic [15:0] w, input int waits);
    for (int i = 0; i < waits; i++) begin
      cyc(1'b0, 1'b0, 16'h0);
      chk("fwait_memReq", {15'h0, memReq}, 16'h1);
      chk("fwait_pcInc",  {15'h0, pcInc},  16'h0);
    end
    cyc(1'b0, 1'b1, w);
    chk("fwait_ack_pcInc", {15'h0, pcInc}, 16'h1);
    cyc(1'b0, 1'b1, 16'hFFFF);  // ack outside a wait state must be ignored
    chk("decode_regNotOE",   {8'h0, regNotOE},   16'hFF);
    chk("decode_regNotLoad", {8'h0, regNotLoad}, 16'hFF);
    chk("decode_pcInc",      {15'h0, pcInc},     16'h0);
  endtask

  // Invariant monitor over every cycle once the DUT has been reset.
  always @(negedge clock) begin
    if (mon_en) begin
      n_cmp++;
      if ($countones(~regNotOE) > 1 || $countones(~regNotLoad) > 1 ||
          (!memNotOE && !aluNotOE) || (!regNotLoad[7] && pcInc)) begin
        n_fail++;
        $display("FAIL invariant: regNotOE=%h regNotLoad=%h memNotOE=%b aluNotOE=%b pcInc=%b",
                 regNotOE, regNotLoad, memNotOE, aluNotOE, pcInc);
      end
    end
  end

  initial begin
    int fetches;
    int budget;
    logic [3:0] op;
    logic [15:0] w;
    logic rr;

    //         instr     imm       kind     waits oe_a   oe_x   ld     aop   pinc
    vecs[0] = '{16'h40CA, 16'h0000, K_ALU2,  3, 8'hFD, 8'hFB, 8'hF7, 4'h4, 1'b0}; // ADD r3,r1,r2
    vecs[1] = '{16'h1170, 16'h0000, K_UNARY, 0, 8'hFF, 8'hBF, 8'hDF, 4'h1, 1'b0}; // MOV r5,r6
    vecs[2] = '{16'h3000, 16'h0000, K_UNARY, 1, 8'hFF, 8'hFE, 8'hFE, 4'h3, 1'b0}; // NOT r0,r0
    vecs[3] = '{16'h50A4, 16'h0000, K_ALU2,  1, 8'hEF, 8'hEF, 8'hFB, 4'h5, 1'b0}; // SUB r2,r4,r4
    vecs[4] = '{16'h81B8, 16'h0000, K_ALU2,  2, 8'h7F, 8'hFE, 8'hBF, 4'h8, 1'b0}; // XOR r6,r7,r0
    vecs[5] = '{16'h7E53, 16'h0000, K_ALU2,  0, 8'hFB, 8'hF7, 8'hFD, 4'h7, 1'b0}; // OR r1,r2,r3 rsvd=111
    vecs[6] = '{16'h61CA, 16'h0000, K_ALU2,  0, 8'hFD, 8'hFB, 8'h7F, 4'h6, 1'b0}; // AND r7,r1,r2
    vecs[7] = '{16'h0000, 16'h0000, K_NOP,   1, 8'hFF, 8'hFF, 8'hFF, 4'h0, 1'b0}; // NOP
    vecs[8] = '{16'h21C0, 16'h0100, K_LDI,   0, 8'hFF, 8'hFF, 8'h7F, 4'h0, 1'b0}; // LDI r7
    vecs[9] = '{16'h2100, 16'hBEEF, K_LDI,   2, 8'hFF, 8'hFF, 8'hEF, 4'h0, 1'b1}; // LDI r4

    cyc(1'b1, 1'b0, 16'h0);
    cyc(1'b1, 1'b0, 16'h0);
    mon_en = 1'b1;
    reset_to_fetch();

    // Directed instruction table; each iteration starts and ends in FETCH.
    foreach (vecs[k]) begin
      chk("tbl_fetch_regNotOE", {8'h0, regNotOE}, 16'h7F);
      chk("tbl_fetch_memReq",   {15'h0, memReq},  16'h1);
      fetch_word(vecs[k].instr, vecs[k].waits);
      case (vecs[k].kind)
        K_ALU2: begin
          cyc(1'b0, 1'b0, 16'h0);
          chk("opa_regNotOE",    {8'h0, regNotOE},     {8'h0, vecs[k].oe_a});
          chk("opa_aluANotLoad", {15'h0, aluANotLoad}, 16'h0);
          cyc(1'b0, 1'b0, 16'h0);
          chk("exec_regNotOE",   {8'h0, regNotOE},     {8'h0, vecs[k].oe_x});
          chk("exec_regNotLoad", {8'h0, regNotLoad},   {8'h0, vecs[k].ld});
          chk("exec_aluNotOE",   {15'h0, aluNotOE},    16'h0);
          chk("exec_aluOp",      {12'h0, aluOp},       {12'h0, vecs[k].aop});
          chk("exec_pcInc",      {15'h0, pcInc},       16'h0);
        end
        K_UNARY: begin
          cyc(1'b0, 1'b0, 16'h0);
          chk("uexec_regNotOE",   {8'h0, regNotOE},   {8'h0, vecs[k].oe_x});
          chk("uexec_regNotLoad", {8'h0, regNotLoad}, {8'h0, vecs[k].ld});
          chk("uexec_aluNotOE",   {15'h0, aluNotOE},  16'h0);
          chk("uexec_aluOp",      {12'h0, aluOp},     {12'h0, vecs[k].aop});
        end
        K_LDI: begin
          cyc(1'b0, 1'b0, 16'h0);
          chk("iaddr_regNotOE",    {8'h0, regNotOE},     16'h7F);
          chk("iaddr_addrNotLoad", {15'h0, addrNotLoad}, 16'h0);
          cyc(1'b0, 1'b1, vecs[k].imm);
          chk("iwait_regNotLoad", {8'h0, regNotLoad}, {8'h0, vecs[k].ld});
          chk("iwait_memNotOE",   {15'h0, memNotOE},  16'h0);
          chk("iwait_pcInc",      {15'h0, pcInc},     {15'h0, vecs[k].pinc});
        end
        default: ;
      endcase
      cyc(1'b0, 1'b0, 16'h0);
    end
    chk("tbl_end_fetch", {8'h0, regNotOE}, 16'h7F);

    // Undefined opcode: halts with the sticky flag, immune to memAck.
    fetch_word(16'hA000, 0);
    cyc(1'b0, 1'b0, 16'h0);
    chk("ill_halted",  {15'h0, halted},  16'h1);
    chk("ill_illegal", {15'h0, illegal}, 16'h1);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'(i % 2), 16'h40CA);
      chk("ill_hold", {6'h0, halted, illegal, regNotOE}, {6'h0, 2'b11, 8'hFF});
      chk("ill_memReq", {15'h0, memReq}, 16'h0);
    end
    cyc(1'b1, 1'b0, 16'h0);
    reset_to_fetch();

    // HALT opcode: halted without the illegal flag.
    fetch_word(16'hF000, 1);
    cyc(1'b0, 1'b0, 16'h0);
    chk("halt_halted",  {15'h0, halted},  16'h1);
    chk("halt_illegal", {15'h0, illegal}, 16'h0);
    cyc(1'b1, 1'b0, 16'h0);
    reset_to_fetch();

    // Reset arriving in FWAIT together with the acknowledge.
    cyc(1'b0, 1'b0, 16'h0);
    cyc(1'b1, 1'b1, 16'h40CA);
    chk("fwrst_still_wait", {15'h0, memReq}, 16'h1);
    reset_to_fetch();

    // Reset arriving in EXEC: the pending load must not reappear.
    fetch_word(16'h40CA, 0);
    cyc(1'b0, 1'b0, 16'h0);
    cyc(1'b1, 1'b0, 16'h0);
    chk("exrst_exec_load", {8'h0, regNotLoad}, 16'hF7);
    reset_to_fetch();

    // Random stream; halts and occasional mid-flight resets are recovered by reset.
    fetches = 0;
    budget  = 0;
    while (fetches < 2000 && budget < 60000) begin
      op = ($urandom_range(0, 31) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      w  = {op, 12'($urandom)};
      rr = (halted === 1'b1) || ($urandom_range(0, 199) == 0);
      cyc(rr, 1'($urandom_range(0, 1)), w);
      if (addrNotLoad === 1'b0) fetches++;
      budget++;
    end
    chk("random_fetch_count_reached", {15'h0, (fetches >= 2000)}, 16'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
